// File: rtl/onewire_pkg.sv
// Shared one-wire slot definitions used by both the command transmitter and receiver.
package onewire_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RST_LOW,
        ST_RST_REL,
        ST_BIT,
        ST_DONE
    } state_t;

    localparam int unsigned SLOT_CYCLES   = 71;
    localparam int unsigned RX_SAMPLE_OFS = 30;
    localparam int unsigned FRAME_BITS    = 8;
    localparam int unsigned CNT_W         = 10;

endpackage

// File: rtl/ow_slot_timer.sv
// Loadable down-counter: terminal count at zero plus >= / == compares against a runtime value.
module ow_slot_timer #(
    parameter int unsigned W = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic [W-1:0] cmp_val,
    output logic         tc,
    output logic         ge,
    output logic         eq
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign tc = (count == '0);
    assign ge = (count >= cmp_val);
    assign eq = (count == cmp_val);

endmodule

// File: rtl/cmd_transmitter.sv
// One-wire command transmitter: LSB-first bit-slot serializer with bus reset/presence sequence.
module cmd_transmitter #(
    parameter int unsigned SLOT_CYCLES    = onewire_pkg::SLOT_CYCLES,
    parameter int unsigned LOW1_CYCLES    = 6,
    parameter int unsigned LOW0_CYCLES    = 60,
    parameter int unsigned RST_LOW_CYCLES = 480,
    parameter int unsigned RST_REL_CYCLES = 480,
    parameter int unsigned PRES_SAMPLE    = 70
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       reset_req,
    input  logic [7:0] frame_in,
    inout  wire        bus,
    output logic       bus_oe,
    output logic       busy,
    output logic       done,
    output logic       presence,
    output logic       presence_valid
);

    import onewire_pkg::*;

    // The timer counts down, so slot offset = load value - count.
    localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SLOT_CYCLES - 1);
    localparam logic [CNT_W-1:0] RLOW_LAST = CNT_W'(RST_LOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] RREL_LAST = CNT_W'(RST_REL_CYCLES - 1);
    localparam logic [CNT_W-1:0] THR1      = CNT_W'(SLOT_CYCLES - LOW1_CYCLES);
    localparam logic [CNT_W-1:0] THR0      = CNT_W'(SLOT_CYCLES - LOW0_CYCLES);
    localparam logic [CNT_W-1:0] PRES_CMP  = CNT_W'(RST_REL_CYCLES - 1 - PRES_SAMPLE);
    localparam logic [2:0]       LAST_BIT  = 3'(FRAME_BITS - 1);

    state_t           state, state_n;
    logic [7:0]       sreg;
    logic [2:0]       bit_idx;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic [CNT_W-1:0] cmp_val;
    logic             tc, ge, eq;
    logic             latch, shift;
    logic             bus_oe_n, done_n, busy_n, pv_n;

    assign bus = bus_oe ? 1'b0 : 1'bz;

    ow_slot_timer #(.W(CNT_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .cmp_val  (cmp_val),
        .tc       (tc),
        .ge       (ge),
        .eq       (eq)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n  = state;
        tmr_load = 1'b0;
        tmr_val  = '0;
        latch    = 1'b0;
        shift    = 1'b0;
        cmp_val  = sreg[0] ? THR1 : THR0;
        unique case (state)
            ST_IDLE: begin
                if (reset_req) begin
                    state_n  = ST_RST_LOW;
                    tmr_load = 1'b1;
                    tmr_val  = RLOW_LAST;
                end else if (start) begin
                    state_n  = ST_BIT;
                    tmr_load = 1'b1;
                    tmr_val  = SLOT_LAST;
                    latch    = 1'b1;
                end
            end
            ST_RST_LOW: begin
                if (tc) begin
                    state_n  = ST_RST_REL;
                    tmr_load = 1'b1;
                    tmr_val  = RREL_LAST;
                end
            end
            ST_RST_REL: begin
                cmp_val = PRES_CMP;
                if (tc) state_n = ST_IDLE;
            end
            ST_BIT: begin
                if (tc) begin
                    shift = 1'b1;
                    if (bit_idx == LAST_BIT) begin
                        state_n = ST_DONE;
                    end else begin
                        tmr_load = 1'b1;
                        tmr_val  = SLOT_LAST;
                    end
                end
            end
            ST_DONE: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase

        // Outputs are computed from the current state and registered one cycle later.
        bus_oe_n = (state == ST_RST_LOW) || ((state == ST_BIT) && ge);
        done_n   = (state == ST_DONE);
        busy_n   = (state != ST_IDLE);
        pv_n     = (state == ST_RST_REL) && eq;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sreg           <= '0;
            bit_idx        <= '0;
            bus_oe         <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            presence       <= 1'b0;
            presence_valid <= 1'b0;
        end else begin
            if (latch) begin
                sreg    <= frame_in;
                bit_idx <= '0;
            end else if (shift) begin
                sreg    <= {1'b0, sreg[7:1]};
                bit_idx <= bit_idx + 3'd1;
            end
            bus_oe         <= bus_oe_n;
            busy           <= busy_n;
            done           <= done_n;
            presence_valid <= pv_n;
            if (pv_n) presence <= ~bus;
        end
    end

endmodule

// File: tb/tb_cmd_transmitter.sv
// Directed bench for cmd_transmitter: frame table, reset/presence, abort and back-to-back cases.
module tb_cmd_transmitter;

    import onewire_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       reset_req = 1'b0;
    logic [7:0] frame_in = '0;
    logic       slave_pull = 1'b0;
    wire        bus;
    logic       bus_oe, busy, done, presence, presence_valid;

    int checks = 0;
    int errs = 0;

    typedef struct {
        logic [7:0] frame;
        logic [7:0] exp_rx;
        int         exp_long;
    } vec_t;

    vec_t vecs [5];

    pullup (bus);
    assign bus = slave_pull ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    cmd_transmitter #(
        .SLOT_CYCLES    (71),
        .LOW1_CYCLES    (6),
        .LOW0_CYCLES    (60),
        .RST_LOW_CYCLES (480),
        .RST_REL_CYCLES (480),
        .PRES_SAMPLE    (70)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .reset_req      (reset_req),
        .frame_in       (frame_in),
        .bus            (bus),
        .bus_oe         (bus_oe),
        .busy           (busy),
        .done           (done),
        .presence       (presence),
        .presence_valid (presence_valid)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Called just after the edge that accepted start; returns on the edge 570 cycles later.
    task automatic watch(input logic [7:0] f, input logic [7:0] exp_rx, input int exp_long,
                         input bit chain, input logic [7:0] nf, input bit poke);
        int         lowc [8];
        bit         marg [8];
        logic [7:0] rx;
        int         dcount;
        int         longs;
        int         k;
        int         ofs;
        rx = '0;
        dcount = 0;
        longs = 0;
        for (int i = 0; i < 8; i++) begin
            lowc[i] = 0;
            marg[i] = 1'b1;
        end
        for (int t = 0; t < 570; t++) begin
            @(negedge clk);
            if (t == 0) begin
                start = 1'b0;
                check("busy_t0", busy, 0);
                check("oe_t0", bus_oe, 0);
                check("done_t0", done, 0);
            end
            if (poke && t == 200) begin
                start = 1'b1;
                reset_req = 1'b1;
                frame_in = ~f;
            end
            if (poke && t == 201) begin
                start = 1'b0;
                reset_req = 1'b0;
            end
            if (done) dcount++;
            if (t >= 1 && t <= 568) begin
                k = (t - 1) / 71;
                ofs = (t - 1) % 71;
                if (bus === 1'b0) lowc[k]++;
                if (ofs >= 60 && bus !== 1'b1) marg[k] = 1'b0;
                if (ofs == int'(RX_SAMPLE_OFS)) rx[k] = bus;
                if (ofs == 70) begin
                    check($sformatf("low_slot%0d", k), lowc[k], f[k] ? 6 : 60);
                    check($sformatf("margin_slot%0d", k), marg[k], 1);
                    if (lowc[k] == 60) longs++;
                end
            end
            if (t == 1) begin
                check("busy_t1", busy, 1);
                check("oe_t1", bus_oe, 1);
            end
            if (t == 569) begin
                check("done_t569", done, 1);
                check("busy_t569", busy, 1);
                if (chain) begin
                    start = 1'b1;
                    frame_in = nf;
                end
            end
        end
        check("rx_frame", rx, exp_rx);
        check("done_count", dcount, 1);
        check("long_slots", longs, exp_long);
        @(posedge clk);
    endtask

    task automatic send(input logic [7:0] f, input logic [7:0] exp_rx, input int exp_long,
                        input bit chain, input logic [7:0] nf, input bit poke);
        @(negedge clk);
        start = 1'b1;
        frame_in = f;
        @(posedge clk);
        watch(f, exp_rx, exp_long, chain, nf, poke);
    endtask

    task automatic reset_seq(input bit slave, input bit with_start, input logic exp_pres);
        int oe_hi;
        int pv_cnt;
        int d_cnt;
        oe_hi = 0;
        pv_cnt = 0;
        d_cnt = 0;
        @(negedge clk);
        reset_req = 1'b1;
        start = with_start;
        frame_in = 8'h0F;
        @(posedge clk);
        for (int t = 0; t < 966; t++) begin
            @(negedge clk);
            if (t == 0) begin
                reset_req = 1'b0;
                start = 1'b0;
            end
            slave_pull = slave && (t >= 496) && (t <= 616);
            if (bus_oe) oe_hi++;
            if (presence_valid) pv_cnt++;
            if (done) d_cnt++;
            if (t == 480) check("rst_oe_t480", bus_oe, 1);
            if (t == 481) check("rst_oe_t481", bus_oe, 0);
            if (t == 551) begin
                check("pv_t551", presence_valid, 1);
                check("presence_t551", presence, exp_pres);
            end
            if (t == 960) check("rst_busy_t960", busy, 1);
            if (t == 961) check("rst_busy_t961", busy, 0);
        end
        slave_pull = 1'b0;
        check("rst_oe_cycles", oe_hi, 480);
        check("pv_count", pv_cnt, 1);
        check("rst_no_done", d_cnt, 0);
        check("presence_hold", presence, exp_pres);
    endtask

    initial begin
        int d_cnt;
        int oe_cnt;

        vecs[0] = '{frame: 8'hA5, exp_rx: 8'hA5, exp_long: 4};
        vecs[1] = '{frame: 8'h00, exp_rx: 8'h00, exp_long: 8};
        vecs[2] = '{frame: 8'hFF, exp_rx: 8'hFF, exp_long: 0};
        vecs[3] = '{frame: 8'h3C, exp_rx: 8'h3C, exp_long: 4};
        vecs[4] = '{frame: 8'h81, exp_rx: 8'h81, exp_long: 6};

        repeat (3) @(negedge clk);
        check("reset_oe", bus_oe, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_presence", presence, 0);
        check("reset_pv", presence_valid, 0);
        check("reset_bus", bus, 1);
        rst = 1'b0;

        for (int v = 0; v < 5; v++) begin
            send(vecs[v].frame, vecs[v].exp_rx, vecs[v].exp_long, 1'b0, 8'h00, 1'b0);
            @(negedge clk);
            check("busy_t570", busy, 0);
            check("done_t570", done, 0);
        end

        reset_seq(1'b1, 1'b0, 1'b1);
        reset_seq(1'b0, 1'b0, 1'b0);
        reset_seq(1'b1, 1'b1, 1'b1);

        send(8'hA5, 8'hA5, 4, 1'b0, 8'h00, 1'b1);
        d_cnt = 0;
        oe_cnt = 0;
        repeat (50) begin
            @(negedge clk);
            if (busy) d_cnt++;
            if (bus_oe) oe_cnt++;
        end
        check("ignored_req_busy", d_cnt, 0);
        check("ignored_req_oe", oe_cnt, 0);

        @(negedge clk);
        start = 1'b1;
        frame_in = 8'hA5;
        @(posedge clk);
        for (int t = 0; t <= 224; t++) begin
            @(negedge clk);
            if (t == 0) start = 1'b0;
        end
        check("abort_oe_before", bus_oe, 1);
        check("abort_presence_before", presence, 1);
        rst = 1'b1;
        @(negedge clk);
        check("abort_oe", bus_oe, 0);
        check("abort_busy", busy, 0);
        check("abort_presence", presence, 0);
        check("abort_done", done, 0);
        rst = 1'b0;
        d_cnt = 0;
        oe_cnt = 0;
        repeat (600) begin
            @(negedge clk);
            if (done) d_cnt++;
            if (bus_oe) oe_cnt++;
        end
        check("abort_no_done", d_cnt, 0);
        check("abort_no_oe", oe_cnt, 0);

        send(8'h3C, 8'h3C, 4, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        check("post_abort_idle", busy, 0);

        send(8'h5A, 8'h5A, 4, 1'b1, 8'hC3, 1'b0);
        watch(8'hC3, 8'hC3, 4, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        check("b2b_idle", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
        $finish;
    end

endmodule
